// File: rtl/otter_wb_pkg.sv
// Shared types and defaults for the register-file writeback queue.
package otter_wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_XLEN  = 32;
    localparam int WB_RAW   = 5;

    localparam logic [WB_RAW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_RAW-1:0]  rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/otter_wb_queue_if.sv
// Bus between execute/memory writeback sources, decode lookups and the register-file write port.
interface otter_wb_queue_if #(
    parameter int XLEN = otter_wb_pkg::WB_XLEN,
    parameter int RAW  = otter_wb_pkg::WB_RAW
);
    logic            a_valid;
    logic            a_ready;
    logic [RAW-1:0]  a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [RAW-1:0]  b_rd;
    logic [XLEN-1:0] b_data;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic            rs1_hit;
    logic [XLEN-1:0] rs1_fwd;
    logic            rs2_hit;
    logic [XLEN-1:0] rs2_fwd;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
               rs1_hit, rs1_fwd, rs2_hit, rs2_fwd
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, rs1_addr, rs2_addr,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
               rs1_hit, rs1_fwd, rs2_hit, rs2_fwd
    );

endinterface

// File: rtl/otter_wb_match.sv
// Youngest-match search of one source register against the occupied queue entries.
module otter_wb_match
    import otter_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wb_entry_t                    entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [WB_RAW-1:0]            rs_addr,
    output logic                         hit,
    output logic [WB_XLEN-1:0]           fwd
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (rs_addr != REG_ZERO && i < int'(count) && entries[idx].rd == rs_addr) begin
                hit = 1'b1;
                fwd = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/otter_wb_queue.sv
// In-order writeback queue merging ALU and load results into a single register-file write port.
module otter_wb_queue
    import otter_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int XLEN  = WB_XLEN,
    parameter int RAW   = WB_RAW
) (
    input  logic                       clock,
    input  logic                       reset_n,
    otter_wb_queue_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];

    logic            pop;
    logic            push_a;
    logic            push_b;
    logic            a_ready;
    logic            b_ready;
    logic [CW:0]     free;
    logic [RAW-1:0]  a_rd;
    logic [RAW-1:0]  b_rd;
    logic [XLEN-1:0] a_data;
    logic [XLEN-1:0] b_data;

    assign a_rd   = bus.a_rd;
    assign b_rd   = bus.b_rd;
    assign a_data = bus.a_data;
    assign b_data = bus.b_data;

    // The head slot retires this cycle whenever anything is queued, so it counts as free.
    always_comb begin
        pop     = (count_q != '0);
        free    = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
        a_ready = (free >= (CW+1)'(1));
        push_a  = bus.a_valid && a_ready && (a_rd != REG_ZERO);
        b_ready = (free >= ((CW+1)'(1) + {{CW{1'b0}}, push_a}));
        push_b  = bus.b_valid && b_ready && (b_rd != REG_ZERO);
    end

    always_comb begin
        mem_d  = mem_q;
        tail_d = tail_q;
        if (push_a) begin
            mem_d[tail_d] = '{rd: a_rd, data: a_data};
            tail_d        = tail_d + PW'(1);
        end
        if (push_b) begin
            mem_d[tail_d] = '{rd: b_rd, data: b_data};
            tail_d        = tail_d + PW'(1);
        end
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.rf_we    = pop;
    assign bus.rf_waddr = pop ? mem_q[head_q].rd : REG_ZERO;
    assign bus.rf_wdata = pop ? mem_q[head_q].data : '0;
    assign count        = count_q;

    otter_wb_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .rs_addr (bus.rs1_addr),
        .hit     (bus.rs1_hit),
        .fwd     (bus.rs1_fwd)
    );

    otter_wb_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .rs_addr (bus.rs2_addr),
        .hit     (bus.rs2_hit),
        .fwd     (bus.rs2_fwd)
    );

endmodule

// File: tb/tb_otter_wb_queue.sv
// Directed bench for otter_wb_queue: register-file writes are logged at the commit edge and checked.
module tb_otter_wb_queue;
    import otter_wb_pkg::*;

    logic       clock;
    logic       reset_n;
    logic [2:0] count;
    int         checks;
    int         failures;

    wb_entry_t   drained [$];
    logic [31:0] rf_model [32];

    otter_wb_queue_if bus ();

    otter_wb_queue dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .count   (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The register file commits on the falling edge of a cycle with rf_we high.
    always @(negedge clock) begin
        if (reset_n && bus.rf_we) begin
            drained.push_back('{rd: bus.rf_waddr, data: bus.rf_wdata});
            rf_model[bus.rf_waddr] = bus.rf_wdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid  = 1'b0;
        bus.a_rd     = '0;
        bus.a_data   = '0;
        bus.b_valid  = 1'b0;
        bus.b_rd     = '0;
        bus.b_data   = '0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (count != 3'd0 && n < 50) begin
            cycle();
            n++;
        end
        ok = (count == 3'd0);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.rs1_addr = 5'd5;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd0) begin failures++; $display("[TB] FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata: got %h want 0", bus.rf_wdata); end
        checks++; if (bus.rs1_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit: got %b want 0", bus.rs1_hit); end
        checks++; if (bus.rs1_fwd !== 32'd0) begin failures++; $display("[TB] FAIL reset_fwd: got %h want 0", bus.rs1_fwd); end
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_push();
        int base;
        bit ok;
        base = drained.size();
        bus.a_valid  = 1'b1;
        bus.a_rd     = 5'd5;
        bus.a_data   = 32'h1234;
        bus.rs1_addr = 5'd5;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_a_ready: got %b want 1", bus.a_ready); end
        checks++; if (bus.rs1_hit !== 1'b0) begin failures++; $display("[TB] FAIL single_inflight_hit: got %b want 0", bus.rs1_hit); end
        cycle();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("[TB] FAIL single_rf_we: got %b want 1", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd5) begin failures++; $display("[TB] FAIL single_waddr: got %0d want 5", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'h1234) begin failures++; $display("[TB] FAIL single_wdata: got %h want 1234", bus.rf_wdata); end
        checks++; if (bus.rs1_hit !== 1'b1) begin failures++; $display("[TB] FAIL single_hit: got %b want 1", bus.rs1_hit); end
        checks++; if (bus.rs1_fwd !== 32'h1234) begin failures++; $display("[TB] FAIL single_fwd: got %h want 1234", bus.rs1_fwd); end
        checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count: got %0d want 1", count); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL single_drain: count %0d want 0", count); end
        checks++; if (drained.size() - base !== 1) begin failures++; $display("[TB] FAIL single_writes: got %0d want 1", drained.size() - base); end
        checks++; if (bus.rs1_hit !== 1'b0) begin failures++; $display("[TB] FAIL single_hit_after: got %b want 0", bus.rs1_hit); end
        idle_inputs();
    endtask

    task automatic test_same_rd();
        int base;
        bit ok;
        base = drained.size();
        bus.a_valid  = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'hAAAA;
        bus.b_valid  = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hBBBB;
        bus.rs2_addr = 5'd7;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL same_b_ready: got %b want 1", bus.b_ready); end
        cycle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL same_count: got %0d want 2", count); end
        checks++; if (bus.rf_wdata !== 32'hAAAA) begin failures++; $display("[TB] FAIL same_first: got %h want AAAA", bus.rf_wdata); end
        checks++; if (bus.rs2_fwd !== 32'hBBBB) begin failures++; $display("[TB] FAIL same_fwd0: got %h want BBBB", bus.rs2_fwd); end
        cycle();
        checks++; if (bus.rf_wdata !== 32'hBBBB) begin failures++; $display("[TB] FAIL same_second: got %h want BBBB", bus.rf_wdata); end
        checks++; if (bus.rs2_fwd !== 32'hBBBB) begin failures++; $display("[TB] FAIL same_fwd1: got %h want BBBB", bus.rs2_fwd); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL same_drain: count %0d want 0", count); end
        checks++; if (drained.size() - base !== 2) begin failures++; $display("[TB] FAIL same_writes: got %0d want 2", drained.size() - base); end
        checks++; if (rf_model[7] !== 32'hBBBB) begin failures++; $display("[TB] FAIL same_rf7: got %h want BBBB", rf_model[7]); end
        idle_inputs();
    endtask

    task automatic test_fill();
        int   base;
        bit   ok;
        logic exp_b_ready [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_count   [5] = '{0, 2, 3, 4, 4};
        base = drained.size();
        for (int c = 0; c < 5; c++) begin
            bus.a_valid = (c < 4);
            bus.a_rd    = 5'(2 * c + 1);
            bus.a_data  = 32'h1000 + 32'(2 * c + 1);
            bus.b_valid = 1'b1;
            bus.b_rd    = (c < 3) ? 5'(2 * c + 2) : 5'd8;
            bus.b_data  = 32'h1000 + 32'(bus.b_rd);
            #1;
            checks++; if (int'(count) !== exp_count[c]) begin failures++; $display("[TB] FAIL fill_count c%0d: got %0d want %0d", c, count, exp_count[c]); end
            checks++; if (bus.b_ready !== exp_b_ready[c]) begin failures++; $display("[TB] FAIL fill_b_ready c%0d: got %b want %b", c, bus.b_ready, exp_b_ready[c]); end
            if (c < 4) begin
                checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_a_ready c%0d: got %b want 1", c, bus.a_ready); end
            end
            cycle();
        end
        idle_inputs();
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL fill_drain: count %0d want 0", count); end
        checks++; if (drained.size() - base !== 8) begin failures++; $display("[TB] FAIL fill_writes: got %0d want 8", drained.size() - base); end
        for (int i = 0; i < 8 && base + i < drained.size(); i++) begin
            checks++;
            if (drained[base+i].rd !== 5'(i + 1) || drained[base+i].data !== 32'h1000 + 32'(i + 1)) begin
                failures++;
                $display("[TB] FAIL fill_order %0d: got rd=%0d data=%h want rd=%0d data=%h",
                         i, drained[base+i].rd, drained[base+i].data, i + 1, 32'h1000 + 32'(i + 1));
            end
        end
    endtask

    task automatic test_rd_zero();
        int base;
        bit ok;
        base = drained.size();
        bus.a_valid  = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD;
        bus.b_valid  = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h3333;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd3;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_a_ready: got %b want 1", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_b_ready: got %b want 1", bus.b_ready); end
        cycle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL zero_count: got %0d want 1", count); end
        checks++; if (bus.rf_waddr !== 5'd3) begin failures++; $display("[TB] FAIL zero_waddr: got %0d want 3", bus.rf_waddr); end
        checks++; if (bus.rs1_hit !== 1'b0 || bus.rs1_fwd !== 32'd0) begin failures++; $display("[TB] FAIL zero_rs1: got hit=%b fwd=%h want 0/0", bus.rs1_hit, bus.rs1_fwd); end
        checks++; if (bus.rs2_hit !== 1'b1 || bus.rs2_fwd !== 32'h3333) begin failures++; $display("[TB] FAIL zero_rs2: got hit=%b fwd=%h want 1/3333", bus.rs2_hit, bus.rs2_fwd); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_drain: count %0d want 0", count); end
        checks++; if (drained.size() - base !== 1) begin failures++; $display("[TB] FAIL zero_writes: got %0d want 1", drained.size() - base); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        int base;
        bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'h10;
        bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'h11;
        cycle();
        bus.a_rd = 5'd12; bus.a_data = 32'h12;
        bus.b_rd = 5'd13; bus.b_data = 32'h13;
        cycle();
        idle_inputs();
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL mid_count: got %0d want 3", count); end
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("[TB] FAIL mid_rf_we: got %b want 1", bus.rf_we); end
        base = drained.size();
        #1 reset_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL mid_reset_count: got %0d want 0", count); end
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_rf_we: got %b want 0", bus.rf_we); end
        cycle();
        cycle();
        reset_n = 1'b1;
        repeat (4) cycle();
        checks++; if (drained.size() !== base) begin failures++; $display("[TB] FAIL mid_no_writes: got %0d want 0", drained.size() - base); end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL mid_count_after: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        int        base;
        int        issued;
        int        cyc;
        bit        a_pend;
        bit        b_pend;
        bit        ok;
        wb_entry_t expq [$];
        base   = drained.size();
        issued = 0;
        cyc    = 0;
        a_pend = 1'b0;
        b_pend = 1'b0;
        while ((issued < 12 || a_pend || b_pend) && cyc < 300) begin
            if (!a_pend && issued < 12 && $urandom_range(0, 1) == 1) begin
                bus.a_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.a_data = $urandom;
                a_pend     = 1'b1;
                issued++;
            end
            if (!b_pend && issued < 12 && $urandom_range(0, 1) == 1) begin
                bus.b_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.b_data = $urandom;
                b_pend     = 1'b1;
                issued++;
            end
            bus.a_valid = a_pend;
            bus.b_valid = b_pend;
            #1;
            if (a_pend && bus.a_ready) begin
                if (bus.a_rd != 5'd0) expq.push_back('{rd: bus.a_rd, data: bus.a_data});
                a_pend = 1'b0;
            end
            if (b_pend && bus.b_ready) begin
                if (bus.b_rd != 5'd0) expq.push_back('{rd: bus.b_rd, data: bus.b_data});
                b_pend = 1'b0;
            end
            cycle();
            cyc++;
        end
        idle_inputs();
        checks++; if (a_pend || b_pend) begin failures++; $display("[TB] FAIL wrap_accept_timeout: pending a=%b b=%b want none", a_pend, b_pend); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL wrap_drain: count %0d want 0", count); end
        checks++; if (drained.size() - base !== expq.size()) begin failures++; $display("[TB] FAIL wrap_writes: got %0d want %0d", drained.size() - base, expq.size()); end
        for (int i = 0; i < expq.size() && base + i < drained.size(); i++) begin
            checks++;
            if (drained[base+i] !== expq[i]) begin
                failures++;
                $display("[TB] FAIL wrap_order %0d: got rd=%0d data=%h want rd=%0d data=%h",
                         i, drained[base+i].rd, drained[base+i].data, expq[i].rd, expq[i].data);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_push();
        test_same_rd();
        test_fill();
        test_rd_zero();
        test_reset_mid_drain();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
